// File: rtl/riscvi2oi_inst_decode_buf_if.sv
// Val/rdy bundle between fetch, the decode buffer and its consumer.
// master drives instructions and out_rdy; slave is the decode stage.
interface riscvi2oi_inst_decode_buf_if #(
    parameter int PC_SZ = 32
);
    logic             in_val;
    logic             in_rdy;
    logic [31:0]      in_inst;
    logic [PC_SZ-1:0] in_pc;
    logic             squash;
    logic             out_val;
    logic             out_rdy;
    logic [PC_SZ-1:0] out_pc;
    logic [6:0]       out_opcode;
    logic [2:0]       out_funct3;
    logic [6:0]       out_funct7;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic             out_rs1_en;
    logic             out_rs2_en;
    logic             out_rd_en;
    logic [2:0]       out_fmt;
    logic [31:0]      out_imm;
    logic             out_illegal;

    modport master (
        output in_val, in_inst, in_pc, squash, out_rdy,
        input  in_rdy, out_val, out_pc, out_opcode, out_funct3,
        input  out_funct7, out_rs1, out_rs2, out_rd,
        input  out_rs1_en, out_rs2_en, out_rd_en,
        input  out_fmt, out_imm, out_illegal
    );

    modport slave (
        input  in_val, in_inst, in_pc, squash, out_rdy,
        output in_rdy, out_val, out_pc, out_opcode, out_funct3,
        output out_funct7, out_rs1, out_rs2, out_rd,
        output out_rs1_en, out_rs2_en, out_rd_en,
        output out_fmt, out_imm, out_illegal
    );
endinterface

// File: rtl/riscvi2oi_inst_decode_buf.sv
// Buffered RV32I decode stage: combinational decode, main reg + skid entry.
// Optional macro RISCV_DECODE_MULDIV_EN makes funct7=0000001 R-type legal.
module riscvi2oi_inst_decode_buf #(
    parameter int PC_SZ = 32
) (
    input logic clk,
    input logic reset,
    riscvi2oi_inst_decode_buf_if.slave bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_SB  = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_UJ  = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

`ifdef RISCV_DECODE_MULDIV_EN
    localparam logic MULDIV = 1'b1;
`else
    localparam logic MULDIV = 1'b0;
`endif

    typedef struct packed {
        logic [PC_SZ-1:0] pc;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             rs1_en;
        logic             rs2_en;
        logic             rd_en;
        logic [2:0]       fmt;
        logic [31:0]      imm;
        logic             illegal;
    } ent_t;

    ent_t        dec;
    ent_t        main_q, main_d;
    ent_t        skid_q, skid_d;
    logic        main_val_q, main_val_d;
    logic        skid_val_q, skid_val_d;
    logic [31:0] inst;
    logic        r_bad;
    logic        alt_bad;
    logic        ill;
    logic        in_fire;
    logic        out_fire;

    assign inst = bus.in_inst;

    always_comb begin
        dec        = '0;
        dec.pc     = bus.in_pc;
        dec.opcode = inst[6:0];
        dec.funct3 = inst[14:12];
        dec.funct7 = inst[31:25];
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.rd     = inst[11:7];
        case (inst[6:0])
            7'b0110011:                         dec.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: dec.fmt = FMT_I;
            7'b0100011:                         dec.fmt = FMT_S;
            7'b1100011:                         dec.fmt = FMT_SB;
            7'b0110111, 7'b0010111:             dec.fmt = FMT_U;
            7'b1101111:                         dec.fmt = FMT_UJ;
            default:                            dec.fmt = FMT_ILL;
        endcase
        case (dec.fmt)
            FMT_I:  dec.imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:  dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_SB: dec.imm = {{20{inst[31]}}, inst[7], inst[30:25],
                               inst[11:8], 1'b0};
            FMT_U:  dec.imm = {inst[31:12], 12'b0};
            FMT_UJ: dec.imm = {{12{inst[31]}}, inst[19:12], inst[20],
                               inst[30:21], 1'b0};
            default: dec.imm = '0;
        endcase
        r_bad = (dec.fmt == FMT_R) &&
                !(dec.funct7 == 7'b0000000 || dec.funct7 == 7'b0100000 ||
                  (MULDIV && dec.funct7 == 7'b0000001));
        // The alternate funct7 only pairs with SUB/SRA-style funct3 values.
        alt_bad = (dec.funct7 == 7'b0100000) &&
                  (dec.funct3 != 3'b000) && (dec.funct3 != 3'b101);
        ill = (dec.fmt == FMT_ILL) || r_bad || alt_bad;
        dec.illegal = ill;
        dec.rs1_en  = !ill && (dec.fmt == FMT_R || dec.fmt == FMT_I ||
                               dec.fmt == FMT_S || dec.fmt == FMT_SB);
        dec.rs2_en  = !ill && (dec.fmt == FMT_R || dec.fmt == FMT_S ||
                               dec.fmt == FMT_SB);
        dec.rd_en   = !ill && (dec.rd != 5'd0) &&
                      (dec.fmt == FMT_R || dec.fmt == FMT_I ||
                       dec.fmt == FMT_U || dec.fmt == FMT_UJ);
    end

    assign bus.in_rdy = !reset && !skid_val_q;
    assign in_fire    = bus.in_val && bus.in_rdy && !bus.squash;
    assign out_fire   = main_val_q && bus.out_rdy && !bus.squash;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_val_d = main_val_q;
        skid_val_d = skid_val_q;
        if (bus.squash) begin
            main_val_d = 1'b0;
            skid_val_d = 1'b0;
        end else if (out_fire || !main_val_q) begin
            if (skid_val_q) begin
                main_d     = skid_q;
                main_val_d = 1'b1;
                skid_val_d = in_fire;
                if (in_fire) skid_d = dec;
            end else begin
                main_val_d = in_fire;
                if (in_fire) main_d = dec;
            end
        end else if (in_fire) begin
            skid_d     = dec;
            skid_val_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_val_q <= 1'b0;
            skid_val_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_val_q <= main_val_d;
            skid_val_q <= skid_val_d;
        end
    end

    assign bus.out_val     = main_val_q;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_opcode  = main_q.opcode;
    assign bus.out_funct3  = main_q.funct3;
    assign bus.out_funct7  = main_q.funct7;
    assign bus.out_rs1     = main_q.rs1;
    assign bus.out_rs2     = main_q.rs2;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_rs1_en  = main_q.rs1_en;
    assign bus.out_rs2_en  = main_q.rs2_en;
    assign bus.out_rd_en   = main_q.rd_en;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_illegal = main_q.illegal;
endmodule
